// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32-entry MIPS register file with optional write-to-read bypass
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] r_reg1,
  input  logic [ADDR_WIDTH-1:0] r_reg2,
  input  logic [ADDR_WIDTH-1:0] w_reg,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] r_data1,
  output logic [DATA_WIDTH-1:0] r_data2,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [31:0]           wr_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [31:0]           cnt;
  logic                  we;

  // A write commits only outside reset and never to the hardwired-zero register.
  assign we = RegWrite && (w_reg != '0) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      cnt <= '0;
    end else if (we) begin
      regs[w_reg] <= w_data;
      cnt         <= cnt + 32'd1;
    end
  end

  always_comb begin
    r_data1 = '0;
    if (!rst && (r_reg1 != '0)) begin
      if (BYPASS && we && (w_reg == r_reg1)) r_data1 = w_data;
      else                                   r_data1 = regs[r_reg1];
    end
  end

  always_comb begin
    r_data2 = '0;
    if (!rst && (r_reg2 != '0)) begin
      if (BYPASS && we && (w_reg == r_reg2)) r_data2 = w_data;
      else                                   r_data2 = regs[r_reg2];
    end
  end

  always_comb begin
    dbg_data = '0;
    if (!rst && (dbg_addr != '0)) dbg_data = regs[dbg_addr];
  end

  assign wr_count = cnt;

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file, bypass and non-bypass instances
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  r_reg1, r_reg2, w_reg, dbg_addr;
  logic [31:0] w_data;
  logic        RegWrite;
  logic [31:0] r_data1, r_data2, dbg_data, wr_count;
  logic [31:0] nb_r_data1, nb_r_data2, nb_dbg_data, nb_wr_count;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] act_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .r_reg1(r_reg1), .r_reg2(r_reg2), .w_reg(w_reg),
    .w_data(w_data), .RegWrite(RegWrite), .r_data1(r_data1), .r_data2(r_data2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
  );

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .r_reg1(r_reg1), .r_reg2(r_reg2), .w_reg(w_reg),
    .w_data(w_data), .RegWrite(RegWrite), .r_data1(nb_r_data1), .r_data2(nb_r_data2),
    .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data), .wr_count(nb_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input string name, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    return e;
  endfunction

  // Single committed write: driven at negedge, committed at the following posedge.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    RegWrite = 1'b1;
    w_reg    = addr;
    w_data   = data;
    @(negedge clk);
    RegWrite = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    logic [31:0] a;
    rst = 1'b1;
    #1;
    exp_q.push_back(mk("reset_wr_count", 32'h0));     act_q.push_back(wr_count);
    exp_q.push_back(mk("reset_r_data1", 32'h0));      act_q.push_back(r_data1);
    exp_q.push_back(mk("reset_r_data2", 32'h0));      act_q.push_back(r_data2);
    exp_q.push_back(mk("reset_dbg", 32'h0));          act_q.push_back(dbg_data);
    @(negedge clk);
    rst = 1'b0;
    do_write(5'd5, 32'h1234_5678);
    r_reg1   = 5'd5;
    dbg_addr = 5'd5;
    #1;
    exp_q.push_back(mk("pre_rst_r5", 32'h1234_5678)); act_q.push_back(r_data1);
    exp_q.push_back(mk("pre_rst_count", 32'd1));      act_q.push_back(wr_count);
    #1 rst = 1'b1;
    #1;
    exp_q.push_back(mk("async_rst_r5", 32'h0));       act_q.push_back(r_data1);
    exp_q.push_back(mk("async_rst_count", 32'h0));    act_q.push_back(wr_count);
    exp_q.push_back(mk("async_rst_dbg", 32'h0));      act_q.push_back(dbg_data);
    #1 rst = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_cmp++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.val);
      end
    end
  endtask

  task automatic test_basic;
    exp_t e;
    logic [31:0] a;
    do_write(5'd8, 32'hDEAD_BEEF);
    r_reg2   = 5'd8;
    dbg_addr = 5'd8;
    #1;
    exp_q.push_back(mk("basic_r_data2", 32'hDEAD_BEEF));    act_q.push_back(r_data2);
    exp_q.push_back(mk("basic_dbg", 32'hDEAD_BEEF));        act_q.push_back(dbg_data);
    exp_q.push_back(mk("basic_count", 32'd1));              act_q.push_back(wr_count);
    exp_q.push_back(mk("basic_nb_r_data2", 32'hDEAD_BEEF)); act_q.push_back(nb_r_data2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_cmp++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.val);
      end
    end
  endtask

  task automatic test_reg0;
    exp_t e;
    logic [31:0] a;
    @(negedge clk);
    RegWrite = 1'b1;
    w_reg    = 5'd0;
    w_data   = 32'hFFFF_FFFF;
    r_reg1   = 5'd0;
    dbg_addr = 5'd0;
    #1;
    exp_q.push_back(mk("reg0_bypass", 32'h0));   act_q.push_back(r_data1);
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    exp_q.push_back(mk("reg0_read", 32'h0));     act_q.push_back(r_data1);
    exp_q.push_back(mk("reg0_dbg", 32'h0));      act_q.push_back(dbg_data);
    exp_q.push_back(mk("reg0_count", 32'd1));    act_q.push_back(wr_count);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_cmp++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.val);
      end
    end
  endtask

  task automatic test_bypass;
    exp_t e;
    logic [31:0] a;
    do_write(5'd3, 32'h11);
    RegWrite = 1'b1;
    w_reg    = 5'd3;
    w_data   = 32'h22;
    r_reg1   = 5'd3;
    r_reg2   = 5'd3;
    dbg_addr = 5'd3;
    #1;
    exp_q.push_back(mk("byp_r_data1", 32'h22));    act_q.push_back(r_data1);
    exp_q.push_back(mk("byp_r_data2", 32'h22));    act_q.push_back(r_data2);
    exp_q.push_back(mk("byp_dbg_pre", 32'h11));    act_q.push_back(dbg_data);
    exp_q.push_back(mk("nobyp_r_data1", 32'h11));  act_q.push_back(nb_r_data1);
    exp_q.push_back(mk("nobyp_r_data2", 32'h11));  act_q.push_back(nb_r_data2);
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    exp_q.push_back(mk("byp_dbg_post", 32'h22));   act_q.push_back(dbg_data);
    exp_q.push_back(mk("nobyp_post", 32'h22));     act_q.push_back(nb_r_data1);
    exp_q.push_back(mk("byp_count", 32'd3));       act_q.push_back(wr_count);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_cmp++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.val);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [31:0] a;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    RegWrite = 1'b1; w_reg = 5'd9;  w_data = 32'd1;
    @(negedge clk);
    w_data = 32'd2;
    @(negedge clk);
    w_reg = 5'd10; w_data = 32'd3;
    @(negedge clk);
    RegWrite = 1'b0;
    repeat (2) @(negedge clk);
    r_reg1 = 5'd9;
    r_reg2 = 5'd10;
    #1;
    exp_q.push_back(mk("b2b_r9", 32'd2));      act_q.push_back(r_data1);
    exp_q.push_back(mk("b2b_r10", 32'd3));     act_q.push_back(r_data2);
    exp_q.push_back(mk("b2b_nb_r9", 32'd2));   act_q.push_back(nb_r_data1);
    exp_q.push_back(mk("b2b_count", 32'd3));   act_q.push_back(wr_count);
    exp_q.push_back(mk("b2b_nb_count", 32'd3)); act_q.push_back(nb_wr_count);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_cmp++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.val);
      end
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    logic [31:0] a;
    @(negedge clk);
    force dut.cnt = 32'hFFFF_FFFF;
    #1 release dut.cnt;
    #1;
    exp_q.push_back(mk("wrap_preload", 32'hFFFF_FFFF)); act_q.push_back(wr_count);
    do_write(5'd11, 32'h5);
    dbg_addr = 5'd11;
    #1;
    exp_q.push_back(mk("wrap_count", 32'h0));  act_q.push_back(wr_count);
    exp_q.push_back(mk("wrap_dbg", 32'h5));    act_q.push_back(dbg_data);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_cmp++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.val);
      end
    end
  endtask

  task automatic test_reset_write;
    exp_t e;
    logic [31:0] a;
    @(negedge clk);
    rst      = 1'b1;
    RegWrite = 1'b1;
    w_reg    = 5'd12;
    w_data   = 32'hAA;
    dbg_addr = 5'd12;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.push_back(mk("rstw_count", 32'h0));  act_q.push_back(wr_count);
    exp_q.push_back(mk("rstw_dbg", 32'h0));    act_q.push_back(dbg_data);
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    exp_q.push_back(mk("rstw_first_count", 32'd1)); act_q.push_back(wr_count);
    exp_q.push_back(mk("rstw_first_dbg", 32'hAA));  act_q.push_back(dbg_data);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_cmp++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.val);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    RegWrite = 1'b0;
    r_reg1   = '0;
    r_reg2   = '0;
    w_reg    = '0;
    w_data   = '0;
    dbg_addr = '0;
    test_reset;
    test_basic;
    test_reg0;
    test_bypass;
    test_back_to_back;
    test_wrap;
    test_reset_write;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
